// File: rtl/e203_exu_wbck_sched_if.sv
// rtl/e203_exu_wbck_sched_if.sv - writeback scheduler handshake/regfile bundle
//   alu_i_*  : single-cycle ALU writeback request (valid/ready, rdidx, wdat)
//   lp_i_*   : long-pipe writeback request (valid/ready, rdidx, wdat, err)
//   rf_*_o   : registered register-file write port
//   lp_cnt_o : long-pipe FIFO occupancy
//   slave modport = scheduler side, master modport = requester/regfile side
interface e203_exu_wbck_sched_if #(
    parameter int XLEN     = 32,
    parameter int RFIDX_W  = 5,
    parameter int LP_DEPTH = 2
);
    localparam int CNT_W = $clog2(LP_DEPTH) + 1;

    logic               alu_i_valid;
    logic               alu_i_ready;
    logic [RFIDX_W-1:0] alu_i_rdidx;
    logic [XLEN-1:0]    alu_i_wdat;

    logic               lp_i_valid;
    logic               lp_i_ready;
    logic [RFIDX_W-1:0] lp_i_rdidx;
    logic [XLEN-1:0]    lp_i_wdat;
    logic               lp_i_err;

    logic               rf_wen_o;
    logic [RFIDX_W-1:0] rf_idx_o;
    logic [XLEN-1:0]    rf_dat_o;
    logic [CNT_W-1:0]   lp_cnt_o;

    modport slave (
        input  alu_i_valid, alu_i_rdidx, alu_i_wdat,
        input  lp_i_valid, lp_i_rdidx, lp_i_wdat, lp_i_err,
        output alu_i_ready, lp_i_ready,
        output rf_wen_o, rf_idx_o, rf_dat_o, lp_cnt_o
    );

    modport master (
        output alu_i_valid, alu_i_rdidx, alu_i_wdat,
        output lp_i_valid, lp_i_rdidx, lp_i_wdat, lp_i_err,
        input  alu_i_ready, lp_i_ready,
        input  rf_wen_o, rf_idx_o, rf_dat_o, lp_cnt_o
    );
endinterface

// File: rtl/e203_exu_wbck_sched.sv
// rtl/e203_exu_wbck_sched.sv - merges ALU and long-pipe writebacks onto one regfile write port
//   clk : clock
//   rst : synchronous active-high reset
//   wb  : handshake and regfile bundle (slave side)
// Long-pipe results queue in a LP_DEPTH-entry FIFO and win arbitration, except
// when the ALU has been stalled STARVE_MAX consecutive cycles.
module e203_exu_wbck_sched #(
    parameter int XLEN       = 32,
    parameter int RFIDX_W    = 5,
    parameter int LP_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    e203_exu_wbck_sched_if.slave  wb
);
    localparam int PTR_W = $clog2(LP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);
    localparam int ENT_W = 1 + RFIDX_W + XLEN;

    logic [ENT_W-1:0]   mem_q [LP_DEPTH];
    logic [ENT_W-1:0]   mem_d [LP_DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ST_W-1:0]    starve_q, starve_d;
    logic               rf_wen_q, rf_wen_d;
    logic [RFIDX_W-1:0] rf_idx_q, rf_idx_d;
    logic [XLEN-1:0]    rf_dat_q, rf_dat_d;

    logic               lp_ready;
    logic               fifo_nonempty;
    logic               push;
    logic               force_alu;
    logic               grant_lp;
    logic               alu_ready;
    logic               grant_alu;
    logic [ENT_W-1:0]   head;
    logic               head_err;
    logic [RFIDX_W-1:0] head_idx;
    logic [XLEN-1:0]    head_dat;

    assign head     = mem_q[rptr_q];
    assign head_err = head[ENT_W-1];
    assign head_idx = head[XLEN +: RFIDX_W];
    assign head_dat = head[XLEN-1:0];

    // Ready depends only on occupancy, so a full FIFO refuses a push even in a
    // cycle where the head is popped.
    assign lp_ready      = (cnt_q != CNT_W'(LP_DEPTH));
    assign fifo_nonempty = (cnt_q != '0);
    assign push          = wb.lp_i_valid & lp_ready;
    assign force_alu     = wb.alu_i_valid & (starve_q == ST_W'(STARVE_MAX));
    assign grant_lp      = fifo_nonempty & ~force_alu;
    assign alu_ready     = ~grant_lp;
    assign grant_alu     = wb.alu_i_valid & alu_ready;

    assign wb.alu_i_ready = alu_ready;
    assign wb.lp_i_ready  = lp_ready;
    assign wb.rf_wen_o    = rf_wen_q;
    assign wb.rf_idx_o    = rf_idx_q;
    assign wb.rf_dat_o    = rf_dat_q;
    assign wb.lp_cnt_o    = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(grant_lp);
        starve_d = '0;
        rf_wen_d = 1'b0;
        rf_idx_d = rf_idx_q;
        rf_dat_d = rf_dat_q;

        if (push) begin
            mem_d[wptr_q] = {wb.lp_i_err, wb.lp_i_rdidx, wb.lp_i_wdat};
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (grant_lp) begin
            rptr_d = rptr_q + PTR_W'(1);
        end

        if (wb.alu_i_valid && !alu_ready) begin
            starve_d = (starve_q == ST_W'(STARVE_MAX)) ? starve_q : starve_q + ST_W'(1);
        end

        // Index/data follow every grant, even ones whose write is suppressed
        // (x0 destination or faulted long-pipe result).
        if (grant_lp) begin
            rf_wen_d = ~head_err & (head_idx != '0);
            rf_idx_d = head_idx;
            rf_dat_d = head_dat;
        end else if (grant_alu) begin
            rf_wen_d = (wb.alu_i_rdidx != '0);
            rf_idx_d = wb.alu_i_rdidx;
            rf_dat_d = wb.alu_i_wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            rf_wen_q <= 1'b0;
            rf_idx_q <= '0;
            rf_dat_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            rf_wen_q <= rf_wen_d;
            rf_idx_q <= rf_idx_d;
            rf_dat_q <= rf_dat_d;
        end
    end

    // Entry storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_e203_exu_wbck_sched.sv
// tb/tb_e203_exu_wbck_sched.sv - directed self-checking bench for e203_exu_wbck_sched
module tb_e203_exu_wbck_sched;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    e203_exu_wbck_sched_if #(.XLEN(32), .RFIDX_W(5), .LP_DEPTH(2)) wb ();

    e203_exu_wbck_sched #(
        .XLEN(32), .RFIDX_W(5), .LP_DEPTH(2), .STARVE_MAX(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic v, input logic [4:0] idx, input logic [31:0] dat);
        wb.alu_i_valid = v;
        wb.alu_i_rdidx = idx;
        wb.alu_i_wdat  = dat;
    endtask

    task automatic lp(input logic v, input logic [4:0] idx, input logic [31:0] dat, input logic err);
        wb.lp_i_valid = v;
        wb.lp_i_rdidx = idx;
        wb.lp_i_wdat  = dat;
        wb.lp_i_err   = err;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        alu(1'b0, 5'd0, 32'h0);
        lp(1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        tick();
        chk("rst_wen", wb.rf_wen_o, 1'b0);
        chk("rst_idx", wb.rf_idx_o, 5'd0);
        chk("rst_dat", wb.rf_dat_o, 32'h0);
        chk("rst_cnt", wb.lp_cnt_o, 2'd0);
        chk("rst_lp_ready", wb.lp_i_ready, 1'b1);
        rst = 1'b0;
        tick();

        // ALU only, FIFO empty
        alu(1'b1, 5'd5, 32'hDEADBEEF);
        #1 chk("alu_ready", wb.alu_i_ready, 1'b1);
        tick();
        alu(1'b0, 5'd0, 32'h0);
        chk("alu_wen", wb.rf_wen_o, 1'b1);
        chk("alu_idx", wb.rf_idx_o, 5'd5);
        chk("alu_dat", wb.rf_dat_o, 32'hDEADBEEF);
        tick();
        chk("alu_pulse", wb.rf_wen_o, 1'b0);
        chk("alu_hold_idx", wb.rf_idx_o, 5'd5);

        // x0 suppression, ALU then long pipe
        alu(1'b1, 5'd0, 32'h1234);
        #1 chk("x0_alu_ready", wb.alu_i_ready, 1'b1);
        tick();
        alu(1'b0, 5'd0, 32'h0);
        chk("x0_alu_wen", wb.rf_wen_o, 1'b0);
        chk("x0_alu_dat", wb.rf_dat_o, 32'h1234);
        lp(1'b1, 5'd0, 32'h55, 1'b0);
        #1 chk("x0_lp_ready", wb.lp_i_ready, 1'b1);
        tick();
        lp(1'b0, 5'd0, 32'h0, 1'b0);
        chk("x0_lp_cnt1", wb.lp_cnt_o, 2'd1);
        chk("x0_lp_wen_a", wb.rf_wen_o, 1'b0);
        tick();
        chk("x0_lp_cnt0", wb.lp_cnt_o, 2'd0);
        chk("x0_lp_wen_b", wb.rf_wen_o, 1'b0);
        chk("x0_lp_dat", wb.rf_dat_o, 32'h55);
        tick();
        chk("x0_lp_wen_c", wb.rf_wen_o, 1'b0);

        // Long-pipe priority and latency
        lp(1'b1, 5'd3, 32'h11, 1'b0);
        tick();
        lp(1'b0, 5'd0, 32'h0, 1'b0);
        alu(1'b1, 5'd9, 32'h99);
        #1 chk("pri_alu_stall", wb.alu_i_ready, 1'b0);
        tick();
        chk("pri_lp_wen", wb.rf_wen_o, 1'b1);
        chk("pri_lp_idx", wb.rf_idx_o, 5'd3);
        chk("pri_lp_dat", wb.rf_dat_o, 32'h11);
        chk("pri_alu_ready", wb.alu_i_ready, 1'b1);
        tick();
        alu(1'b0, 5'd0, 32'h0);
        chk("pri_alu_wen", wb.rf_wen_o, 1'b1);
        chk("pri_alu_idx", wb.rf_idx_o, 5'd9);
        tick();
        chk("pri_idle_wen", wb.rf_wen_o, 1'b0);

        // Starvation, backpressure and ordering in one trace
        lp(1'b1, 5'd1, 32'h101, 1'b0);
        tick();
        chk("st_cnt_init", wb.lp_cnt_o, 2'd1);
        alu(1'b1, 5'd10, 32'hA0);
        lp(1'b1, 5'd2, 32'h102, 1'b0);
        #1 chk("st_stall1", wb.alu_i_ready, 1'b0);
        tick();
        chk("st_out_e1", wb.rf_idx_o, 5'd1);
        chk("st_dat_e1", wb.rf_dat_o, 32'h101);
        lp(1'b1, 5'd3, 32'h103, 1'b0);
        #1 chk("st_stall2", wb.alu_i_ready, 1'b0);
        tick();
        chk("st_out_e2", wb.rf_idx_o, 5'd2);
        lp(1'b1, 5'd4, 32'h104, 1'b0);
        #1 chk("st_stall3", wb.alu_i_ready, 1'b0);
        tick();
        chk("st_out_e3", wb.rf_idx_o, 5'd3);
        lp(1'b1, 5'd5, 32'h105, 1'b0);
        #1 chk("st_stall4", wb.alu_i_ready, 1'b0);
        tick();
        chk("st_out_e4", wb.rf_idx_o, 5'd4);
        lp(1'b1, 5'd6, 32'h106, 1'b0);
        #1 chk("st_force", wb.alu_i_ready, 1'b1);
        tick();
        chk("st_alu_wen", wb.rf_wen_o, 1'b1);
        chk("st_alu_idx", wb.rf_idx_o, 5'd10);
        chk("st_alu_dat", wb.rf_dat_o, 32'hA0);
        chk("bp_cnt_full", wb.lp_cnt_o, 2'd2);
        lp(1'b1, 5'd7, 32'h107, 1'b0);
        #1 chk("bp_lp_ready0", wb.lp_i_ready, 1'b0);
        chk("st_restart", wb.alu_i_ready, 1'b0);
        tick();
        chk("bp_out_e5", wb.rf_idx_o, 5'd5);
        chk("bp_dat_e5", wb.rf_dat_o, 32'h105);
        chk("bp_cnt_after_pop", wb.lp_cnt_o, 2'd1);
        #1 chk("bp_lp_ready1", wb.lp_i_ready, 1'b1);
        tick();
        chk("bp_out_e6", wb.rf_idx_o, 5'd6);
        chk("bp_cnt_e7", wb.lp_cnt_o, 2'd1);
        lp(1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        chk("bp_out_e7", wb.rf_idx_o, 5'd7);
        chk("bp_dat_e7", wb.rf_dat_o, 32'h107);
        chk("bp_cnt_empty", wb.lp_cnt_o, 2'd0);
        #1 chk("bp_alu_ready", wb.alu_i_ready, 1'b1);
        tick();
        alu(1'b0, 5'd0, 32'h0);
        chk("bp_alu_idx", wb.rf_idx_o, 5'd10);
        chk("bp_alu_wen", wb.rf_wen_o, 1'b1);
        tick();
        chk("bp_idle_wen", wb.rf_wen_o, 1'b0);

        // Faulted long-pipe result is consumed without a write
        lp(1'b1, 5'd7, 32'h77, 1'b1);
        tick();
        lp(1'b0, 5'd0, 32'h0, 1'b0);
        chk("err_cnt1", wb.lp_cnt_o, 2'd1);
        tick();
        chk("err_wen", wb.rf_wen_o, 1'b0);
        chk("err_idx", wb.rf_idx_o, 5'd7);
        chk("err_cnt0", wb.lp_cnt_o, 2'd0);

        // Mid-operation reset with two entries queued
        lp(1'b1, 5'd20, 32'h200, 1'b0);
        tick();
        alu(1'b1, 5'd11, 32'hB0);
        for (int i = 1; i <= 5; i++) begin
            lp(1'b1, 5'(20 + i), 32'h200 + 32'(i), 1'b0);
            tick();
        end
        chk("mr_cnt_full", wb.lp_cnt_o, 2'd2);
        chk("mr_alu_wen", wb.rf_wen_o, 1'b1);
        alu(1'b0, 5'd0, 32'h0);
        lp(1'b0, 5'd0, 32'h0, 1'b0);
        rst = 1'b1;
        tick();
        chk("mr_cnt0", wb.lp_cnt_o, 2'd0);
        chk("mr_wen0", wb.rf_wen_o, 1'b0);
        chk("mr_idx0", wb.rf_idx_o, 5'd0);
        chk("mr_dat0", wb.rf_dat_o, 32'h0);
        rst = 1'b0;
        tick();
        chk("mr_no_stale_a", wb.rf_wen_o, 1'b0);
        tick();
        chk("mr_no_stale_b", wb.rf_wen_o, 1'b0);
        chk("mr_cnt_stay0", wb.lp_cnt_o, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/e203_exu_wbck_sched.md
Name: e203_exu_wbck_sched

Overview:
- Write-side scheduler for the general-purpose register file.
- Merges single-cycle ALU writebacks and long-pipe writebacks (mul/div, load return) into the register file's single write port.
- Long-pipe results are buffered in a small FIFO.
- Arbitration gives the long pipe priority, with a starvation guard for the ALU.
- Output is registered; it drives the regfile's write-enable, write-index and write-data inputs directly.

Parameters:
- XLEN, 32, data width of a writeback.
- RFIDX_W, 5, register index width.
- LP_DEPTH, 2, long-pipe FIFO entries; power of two, ≥2.
- STARVE_MAX, 4, consecutive stalled ALU cycles before the ALU is forced to win one grant.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- alu_i_valid  in  1  ALU writeback request.
- alu_i_ready  out  1  ALU writeback accepted this cycle.
- alu_i_rdidx  in  RFIDX_W  destination register.
- alu_i_wdat  in  XLEN  write data.
- lp_i_valid  in  1  long-pipe writeback request.
- lp_i_ready  out  1  FIFO can accept.
- lp_i_rdidx  in  RFIDX_W  destination register.
- lp_i_wdat  in  XLEN  write data.
- lp_i_err  in  1  result faulted; consume without writing.
- rf_wen_o  out  1  register-file write enable (registered).
- rf_idx_o  out  RFIDX_W  register-file write index (registered).
- rf_dat_o  out  XLEN  register-file write data (registered).
- lp_cnt_o  out  clog2(LP_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - rf_wen_o=0, rf_idx_o=0, rf_dat_o=0.
  - FIFO emptied: pointers=0, lp_cnt_o=0; starve_cnt=0.
  - Any in-flight entry is discarded; mid-operation reset gives no partial write.
- FIFO:
  - Entry = {err, rdidx, wdat}.
  - lp_i_ready = (lp_cnt_o != LP_DEPTH). It is not a function of lp_i_valid.
  - Push on lp_i_valid & lp_i_ready.
  - Pop when the head is granted.
  - Push and pop in the same cycle leave the count unchanged.
  - No same-cycle bypass. When full, no push occurs even if a pop happens that cycle.
  - Pointers wrap modulo LP_DEPTH.
- Arbitration (combinational, each cycle):
  - force_alu = alu_i_valid & (starve_cnt == STARVE_MAX).
  - grant_lp = fifo_nonempty & ~force_alu.
  - alu_i_ready = ~grant_lp.
  - grant_alu = alu_i_valid & alu_i_ready.
- Starvation counter:
  - If alu_i_valid & ~alu_i_ready: starve_cnt += 1, saturating at STARVE_MAX.
  - Otherwise starve_cnt = 0. This covers both an ALU handshake and alu_i_valid low.
- Output register, at each clk edge:
  - rf_wen_o <= (grant_lp & ~head.err & head.rdidx != 0) | (grant_alu & alu_i_rdidx != 0).
  - rf_idx_o/rf_dat_o load the granted source's rdidx/wdat on any grant, including suppressed ones. With no grant they hold their value.
  - rf_wen_o is a single-cycle pulse per grant.
- Latency:
  - ALU handshake at edge N → rf_wen_o high in cycle N+1.
  - Long-pipe push at edge N → earliest grant in cycle N+1 → rf_wen_o high in cycle N+2.
- Ordering:
  - Long-pipe entries retire in push order.
  - ALU vs long-pipe ordering is not guaranteed by this block; register hazards are resolved upstream.
- x0 and err: writes to index 0 and err entries consume a grant but never assert rf_wen_o.
- Throughput: at most one grant, and at most one register-file write, per cycle.

Test Plan:
- ALU only, FIFO empty:
  - Stimulus: alu_i_valid=1, rdidx=5, wdat=0xDEADBEEF for one cycle.
  - Required: alu_i_ready=1; next cycle rf_wen_o=1, rf_idx_o=5, rf_dat_o=0xDEADBEEF; following cycle rf_wen_o=0.
- x0 suppression:
  - Stimulus: ALU write rdidx=0, then a long-pipe write rdidx=0.
  - Required: rf_wen_o stays 0; both handshakes complete; lp_cnt_o returns to 0.
- Long-pipe priority and latency:
  - Stimulus: lp push rdidx=3, dat=0x11 at cycle 0; ALU valid continuously from cycle 1.
  - Required: cycle 1 alu_i_ready=0; cycle 2 rf_wen_o=1, idx=3, dat=0x11; cycle 2 alu_i_ready=1.
- Backpressure (LP_DEPTH=2):
  - Stimulus: push 3 lp entries back-to-back while ALU valid with force pending.
  - Required: lp_i_ready=0 when lp_cnt_o=2; third entry held until a pop; entries retire in order.
- Starvation (STARVE_MAX=4):
  - Stimulus: keep the FIFO non-empty with continuous lp pushes; ALU valid throughout.
  - Required: ALU stalled exactly 4 cycles; granted on the 5th; starve_cnt then returns to 0.
- err drop and mid-op reset:
  - err: lp entry with err=1, rdidx=7 is popped with rf_wen_o=0.
  - reset: assert rst with 2 entries queued → lp_cnt_o=0, rf_wen_o=0 next cycle, and no stale write after reset deasserts.
